sha256_msg_scheduler: RTL and testbench
=======================================

# sha256_msg_scheduler

Front end that drives `sha256_update_variables` with per-round data. It accepts one 512-bit padded message block through a valid/ready handshake and sequences the compressor control strobes: init, 64 rounds, then digest update. On each round cycle it supplies the expanded message word `w_data` and the round constant `k_out`, and it signals completion per block.

## Interface
Parameters:
- none. Sizes are fixed by SHA-256: 16-word window, 64 rounds, 32-bit words.

Ports:
- `clk`  in  1  sole clock; all state updates on its rising edge.
- `reset_n`  in  1  synchronous, active-low reset.
- `block_valid`  in  1  `block_data` and `block_first` are presented.
- `block_ready`  out  1  scheduler can accept a block.
- `block_data`  in  512  padded block; word 0 (`W[0]`) in [511:480], word 15 in [31:0].
- `block_first`  in  1  block is the first of a message.
- `init_round`  out  1  load A–H (compressor).
- `init_digest`  out  1  load H (compressor).
- `partial_rounds`  out  1  round cycle; `w_data`/`k_out` valid.
- `update_digest`  out  1  H += A–H (compressor).
- `first_block`  out  1  latched `block_first`, held for the whole block.
- `w_data`  out  32  `W[t]` for the current round.
- `k_out`  out  32  `K[t]` for the current round.
- `round_idx`  out  6  current round t.
- `block_done`  out  1  one-cycle pulse when the digest update is issued.

## Operation
- FSM states: IDLE, INIT, ROUND, DIGEST.
- IDLE:
  - `block_ready`=1.
  - On `block_valid && block_ready`: latch the 16 words into the window (`w_reg[i]`=`W[i]`), latch `block_first`, go to INIT.
- INIT (1 cycle):
  - `init_round`=1 and `init_digest`=1.
  - `round_idx`=0.
  - Next state ROUND.
- ROUND (64 cycles, t=0..63):
  - `partial_rounds`=1, `w_data`=`w_reg[0]`, `k_out`=`K[round_idx]`.
  - Every cycle: shift the window down by one (`w_reg[i]`←`w_reg[i+1]`); `w_reg[15]`←`σ1(w_reg[14]) + w_reg[9] + σ0(w_reg[1]) + w_reg[0]`.
  - All additions mod 2^32; carries discarded.
  - `σ0(x)` = ROTR7 ^ ROTR18 ^ SHR3.
  - `σ1(x)` = ROTR17 ^ ROTR19 ^ SHR10.
  - `round_idx` increments each cycle. At `round_idx`=63, go to DIGEST; the counter wraps to 0 and is not used outside ROUND.
- DIGEST (1 cycle):
  - `update_digest`=1, `block_done`=1.
  - Next state IDLE.
- `first_block` is held from INIT through DIGEST. It is cleared to 0 in IDLE.
- `block_valid` outside IDLE is ignored (`block_ready`=0). The block is not consumed and must be held by the source.
- No stall inside a block: once accepted, the block runs to completion.

## Timing
- Reset (`reset_n`=0 at an edge):
  - Next state IDLE.
  - All outputs 0 except `block_ready`=1.
  - Window cleared, `round_idx`=0.
- Reset is honoured in any state, including mid-ROUND. The partial block is discarded and no `block_done` is issued.
- Cycle numbering, with the handshake at cycle 0:
  - INIT at cycle 1.
  - ROUND t at cycle 2+t.
  - DIGEST at cycle 66.
  - `block_ready`=1 again at cycle 67.
- Throughput: one block per 67 cycles.
- Strobes are mutually exclusive except `init_round`/`init_digest`, which are asserted together.
- All outputs are registered-state decodes; no combinational path from `block_valid` to any output other than none (`block_ready` depends only on state).

## Structure
- `sha256_pkg`:
  - `K` constant array (64×32).
  - FSM state enum.
  - `sigma0`/`sigma1` functions.
  - Word-width localparam.
  - `H0_0`..`H0_7` initial hash constants, shared with the compressor top.
- Sub-module `sha256_k_rom`: combinational `round_idx`→`k_out` lookup over the package table.
- The window shift register and the FSM live in `sha256_msg_scheduler`.

## Test plan
- Reset, then the "abc" padded block (`W[0]`=0x61626380, `W[1..14]`=0, `W[15]`=0x00000018) with `block_first`=1:
  - INIT at cycle 1 with `first_block`=1.
  - `w_data`=0x61626380 at t=0.
  - `w_data` at t=16,17,18,19 = 0x61626380, 0x000F0000, 0x7DA86405, 0x600003C6.
- Same run, constants: `k_out`=0x428A2F98 at t=0, 0x71374491 at t=1, 0xC67178F2 at t=63.
- Strobe sequencing:
  - `partial_rounds` high for exactly 64 consecutive cycles.
  - `update_digest` and `block_done` at cycle 66.
  - `block_ready`=0 during cycles 1–66 and 1 at cycle 67.
- `block_valid` held high continuously with a second block (`block_first`=0):
  - Second handshake occurs exactly at cycle 67.
  - Its INIT shows `first_block`=0.
- `reset_n`=0 for one cycle at t=30:
  - Next cycle state is IDLE, all strobes 0, `block_ready`=1.
  - No `block_done` for the aborted block.
  - A new block afterwards produces correct `W[0..19]`.
- Random blocks against a reference expansion model: all 64 `w_data` values match.

Source files
------------

// File: rtl/sha256_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module : sha256_pkg                                                        |
// | Brief  : Shared SHA-256 constants, FSM state type and schedule functions.  |
// | Rev    : 1.0  initial release                                              |
// +----------------------------------------------------------------------------+
package sha256_pkg;

    localparam int WORD_W     = 32;
    localparam int NUM_WORDS  = 16;
    localparam int NUM_ROUNDS = 64;
    localparam int IDX_W      = 6;

    typedef logic [WORD_W-1:0] word_t;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_INIT   = 2'd1,
        ST_ROUND  = 2'd2,
        ST_DIGEST = 2'd3
    } state_t;

    localparam word_t K [NUM_ROUNDS] = '{
        32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5,
        32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
        32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3,
        32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
        32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc,
        32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
        32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7,
        32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
        32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13,
        32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
        32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3,
        32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
        32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5,
        32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
        32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208,
        32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2
    };

    // Initial hash value, consumed by the compressor top.
    localparam word_t H0_0 = 32'h6a09e667;
    localparam word_t H0_1 = 32'hbb67ae85;
    localparam word_t H0_2 = 32'h3c6ef372;
    localparam word_t H0_3 = 32'ha54ff53a;
    localparam word_t H0_4 = 32'h510e527f;
    localparam word_t H0_5 = 32'h9b05688c;
    localparam word_t H0_6 = 32'h1f83d9ab;
    localparam word_t H0_7 = 32'h5be0cd19;

    function automatic word_t rotr(input word_t x, input int unsigned n);
        return (x >> n) | (x << (WORD_W - n));
    endfunction

    function automatic word_t sigma0(input word_t x);
        return rotr(x, 7) ^ rotr(x, 18) ^ (x >> 3);
    endfunction

    function automatic word_t sigma1(input word_t x);
        return rotr(x, 17) ^ rotr(x, 19) ^ (x >> 10);
    endfunction

endpackage : sha256_pkg
`default_nettype wire

// File: rtl/sha256_k_rom.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module : sha256_k_rom                                                      |
// | Brief  : Combinational round-index to round-constant lookup.               |
// | Rev    : 1.0  initial release                                              |
// +----------------------------------------------------------------------------+
module sha256_k_rom
    import sha256_pkg::*;
(
    input  logic [IDX_W-1:0]  round_idx,
    output logic [WORD_W-1:0] k_out
);

    assign k_out = K[round_idx];

endmodule : sha256_k_rom
`default_nettype wire

// File: rtl/sha256_msg_scheduler.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module : sha256_msg_scheduler                                              |
// | Brief  : Accepts a 512-bit block, expands W[t] and sequences compressor.   |
// | Rev    : 1.0  initial release                                              |
// +----------------------------------------------------------------------------+
module sha256_msg_scheduler
    import sha256_pkg::*;
(
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic                 block_valid,
    output logic                 block_ready,
    input  logic [511:0]         block_data,
    input  logic                 block_first,
    output logic                 init_round,
    output logic                 init_digest,
    output logic                 partial_rounds,
    output logic                 update_digest,
    output logic                 first_block,
    output logic [WORD_W-1:0]    w_data,
    output logic [WORD_W-1:0]    k_out,
    output logic [IDX_W-1:0]     round_idx,
    output logic                 block_done
);

    localparam logic [IDX_W-1:0] C_LAST_ROUND = IDX_W'(NUM_ROUNDS - 1);

    state_t           r_state;
    word_t            r_w [NUM_WORDS];
    logic [IDX_W-1:0] r_round_idx;
    logic             r_block_ready;
    logic             r_init;
    logic             r_partial_rounds;
    logic             r_update_digest;
    logic             r_first_block;
    word_t            w_next;
    word_t            w_k;

    // W[t+16] from the window holding W[t]..W[t+15].
    assign w_next = sigma1(r_w[14]) + r_w[9] + sigma0(r_w[1]) + r_w[0];

    sha256_k_rom u_k_rom (
        .round_idx (r_round_idx),
        .k_out     (w_k)
    );

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_state          <= ST_IDLE;
            r_round_idx      <= '0;
            r_block_ready    <= 1'b1;
            r_init           <= 1'b0;
            r_partial_rounds <= 1'b0;
            r_update_digest  <= 1'b0;
            r_first_block    <= 1'b0;
            for (int i = 0; i < NUM_WORDS; i++) begin
                r_w[i] <= '0;
            end
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (block_valid && r_block_ready) begin
                        r_state       <= ST_INIT;
                        r_block_ready <= 1'b0;
                        r_init        <= 1'b1;
                        r_first_block <= block_first;
                        r_round_idx   <= '0;
                        for (int i = 0; i < NUM_WORDS; i++) begin
                            r_w[i] <= block_data[511 - WORD_W*i -: WORD_W];
                        end
                    end
                end
                ST_INIT: begin
                    r_state          <= ST_ROUND;
                    r_init           <= 1'b0;
                    r_partial_rounds <= 1'b1;
                    r_round_idx      <= '0;
                end
                ST_ROUND: begin
                    for (int i = 0; i < NUM_WORDS - 1; i++) begin
                        r_w[i] <= r_w[i+1];
                    end
                    r_w[NUM_WORDS-1] <= w_next;
                    // Wraps to zero on the last round.
                    r_round_idx <= r_round_idx + 1'b1;
                    if (r_round_idx == C_LAST_ROUND) begin
                        r_state          <= ST_DIGEST;
                        r_partial_rounds <= 1'b0;
                        r_update_digest  <= 1'b1;
                    end
                end
                ST_DIGEST: begin
                    r_state         <= ST_IDLE;
                    r_update_digest <= 1'b0;
                    r_first_block   <= 1'b0;
                    r_block_ready   <= 1'b1;
                end
                default: begin
                    r_state       <= ST_IDLE;
                    r_block_ready <= 1'b1;
                end
            endcase
        end
    end

    assign block_ready    = r_block_ready;
    assign init_round     = r_init;
    assign init_digest    = r_init;
    assign partial_rounds = r_partial_rounds;
    assign update_digest  = r_update_digest;
    assign block_done     = r_update_digest;
    assign first_block    = r_first_block;
    assign round_idx      = r_round_idx;
    // Data outputs are quiet outside round cycles.
    assign w_data         = r_partial_rounds ? r_w[0] : '0;
    assign k_out          = r_partial_rounds ? w_k    : '0;

endmodule : sha256_msg_scheduler
`default_nettype wire

// File: tb/tb_sha256_msg_scheduler.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module : tb_sha256_msg_scheduler                                           |
// | Brief  : Directed and random bench with a plain-arithmetic expansion model.|
// | Rev    : 1.0  initial release                                              |
// +----------------------------------------------------------------------------+
module tb_sha256_msg_scheduler;

    logic         clk = 1'b0;
    logic         reset_n;
    logic         block_valid;
    logic         block_ready;
    logic [511:0] block_data;
    logic         block_first;
    logic         init_round;
    logic         init_digest;
    logic         partial_rounds;
    logic         update_digest;
    logic         first_block;
    logic [31:0]  w_data;
    logic [31:0]  k_out;
    logic [5:0]   round_idx;
    logic         block_done;

    int vectors     = 0;
    int miscompares = 0;
    logic [31:0] ref_w [64];

    always #5 clk = ~clk;

    sha256_msg_scheduler dut (
        .clk            (clk),
        .reset_n        (reset_n),
        .block_valid    (block_valid),
        .block_ready    (block_ready),
        .block_data     (block_data),
        .block_first    (block_first),
        .init_round     (init_round),
        .init_digest    (init_digest),
        .partial_rounds (partial_rounds),
        .update_digest  (update_digest),
        .first_block    (first_block),
        .w_data         (w_data),
        .k_out          (k_out),
        .round_idx      (round_idx),
        .block_done     (block_done)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [31:0] ror(input logic [31:0] x, input int n);
        return (x >> n) | (x << (32 - n));
    endfunction

    // Textbook expansion over the whole 64-word array.
    task automatic build_ref(input logic [511:0] blk);
        for (int t = 0; t < 16; t++) ref_w[t] = blk[511 - 32*t -: 32];
        for (int t = 16; t < 64; t++) begin
            ref_w[t] = (ror(ref_w[t-2], 17) ^ ror(ref_w[t-2], 19) ^ (ref_w[t-2] >> 10))
                     + ref_w[t-7]
                     + (ror(ref_w[t-15], 7) ^ ror(ref_w[t-15], 18) ^ (ref_w[t-15] >> 3))
                     + ref_w[t-16];
        end
    endtask

    task automatic check_idle(input string tag);
        check({tag, ".ready"},   {31'd0, block_ready},    32'd1);
        check({tag, ".init"},    {30'd0, init_round, init_digest}, 32'd0);
        check({tag, ".partial"}, {31'd0, partial_rounds}, 32'd0);
        check({tag, ".update"},  {31'd0, update_digest},  32'd0);
        check({tag, ".done"},    {31'd0, block_done},     32'd0);
        check({tag, ".first"},   {31'd0, first_block},    32'd0);
        check({tag, ".w"},       w_data,                  32'd0);
        check({tag, ".k"},       k_out,                   32'd0);
        check({tag, ".idx"},     {26'd0, round_idx},      32'd0);
    endtask

    // Runs one block from handshake (cycle 0) to ready again (cycle 67).
    // With hold=1 the source keeps valid high and presents the next block.
    // abort_at >= 0 applies a one-cycle reset during that round and returns.
    task automatic run_block(input logic [511:0] blk, input logic first,
                             input logic hold, input logic [511:0] nblk,
                             input logic nfirst, input int abort_at);
        int waited;
        build_ref(blk);
        block_data  = blk;
        block_first = first;
        block_valid = 1'b1;
        waited = 0;
        while (!block_ready && waited < 200) begin
            tick();
            waited++;
        end
        check("handshake_wait", {31'd0, block_ready}, 32'd1);
        tick();
        if (hold) begin
            block_data  = nblk;
            block_first = nfirst;
        end else begin
            block_valid = 1'b0;
        end
        check("init.round",  {31'd0, init_round},     32'd1);
        check("init.digest", {31'd0, init_digest},    32'd1);
        check("init.first",  {31'd0, first_block},    {31'd0, first});
        check("init.ready",  {31'd0, block_ready},    32'd0);
        check("init.idx",    {26'd0, round_idx},      32'd0);
        check("init.part",   {31'd0, partial_rounds}, 32'd0);
        for (int t = 0; t < 64; t++) begin
            tick();
            check("round.partial", {31'd0, partial_rounds}, 32'd1);
            check("round.idx",     {26'd0, round_idx},      t);
            check("round.w",       w_data,                  ref_w[t]);
            check("round.ready",   {31'd0, block_ready},    32'd0);
            check("round.done",    {30'd0, block_done, init_round}, 32'd0);
            check("round.first",   {31'd0, first_block},    {31'd0, first});
            if (t == 0)  check("k0",  k_out, 32'h428a2f98);
            if (t == 1)  check("k1",  k_out, 32'h71374491);
            if (t == 2)  check("k2",  k_out, 32'hb5c0fbcf);
            if (t == 63) check("k63", k_out, 32'hc67178f2);
            if (t == abort_at) begin
                reset_n = 1'b0;
                tick();
                reset_n = 1'b1;
                block_valid = 1'b0;
                check_idle("abort");
                for (int c = 0; c < 70; c++) begin
                    tick();
                    check("abort.nodone", {30'd0, block_done, partial_rounds}, 32'd0);
                end
                return;
            end
        end
        tick();
        check("digest.update",  {31'd0, update_digest},  32'd1);
        check("digest.done",    {31'd0, block_done},     32'd1);
        check("digest.partial", {31'd0, partial_rounds}, 32'd0);
        check("digest.ready",   {31'd0, block_ready},    32'd0);
        tick();
        check("post.ready", {31'd0, block_ready}, 32'd1);
        check("post.done",  {31'd0, block_done},  32'd0);
        check("post.first", {31'd0, first_block}, 32'd0);
    endtask

    initial begin
        logic [511:0] abc;
        logic [511:0] blk2;
        logic [511:0] rnd;
        abc  = {32'h61626380, 448'd0, 32'h00000018};
        blk2 = '0;
        for (int i = 0; i < 16; i++) blk2[32*i +: 32] = $urandom;

        reset_n     = 1'b0;
        block_valid = 1'b0;
        block_data  = '0;
        block_first = 1'b0;
        tick();
        tick();
        check_idle("reset");
        reset_n = 1'b1;
        tick();
        check_idle("idle");

        // "abc" block with fixed expected expansion words.
        build_ref(abc);
        check("ref16", ref_w[16], 32'h61626380);
        check("ref17", ref_w[17], 32'h000f0000);
        check("ref18", ref_w[18], 32'h7da86405);
        check("ref19", ref_w[19], 32'h600003c6);
        run_block(abc, 1'b1, 1'b1, blk2, 1'b0, -1);

        // Valid held: second handshake lands on cycle 67.
        run_block(blk2, 1'b0, 1'b0, '0, 1'b0, -1);

        // Reset mid-block, then a fresh block.
        rnd = '0;
        for (int i = 0; i < 16; i++) rnd[32*i +: 32] = $urandom;
        run_block(rnd, 1'b1, 1'b0, '0, 1'b0, 30);
        run_block(abc, 1'b1, 1'b0, '0, 1'b0, -1);

        for (int n = 0; n < 4; n++) begin
            for (int i = 0; i < 16; i++) rnd[32*i +: 32] = $urandom;
            run_block(rnd, n[0], 1'b0, '0, 1'b0, -1);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule : tb_sha256_msg_scheduler
`default_nettype wire
